// File: rtl/button_pkg.sv
// Shared definitions for the button peripheral: debouncer state encodings,
// the default debounce length and the peripheral acknowledge address.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } button_state_e;

    // 1 ms of stability at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

    localparam logic [31:0] BUTTON_ACK_ADDR = 32'h0000_0400;

endpackage

// File: rtl/button_sync.sv
// N-flop synchroniser for asynchronous external pins. The reset value lets
// each pin start at its own inactive level so no false edge follows reset.
module button_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the pin through the flop chain; only chain[0] sees the raw pin.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioning: synchronise, normalise to 1 = pressed, debounce
// with a stability counter and emit a clean level plus press/release pulses.
// Optional long-press detection is built when BUTTON_LONG_PRESS_EN is defined;
// otherwise long_press is tied low and the port list is unchanged.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | released and stable, button_clean = 0
// PRESS_WAIT   | pressed level seen, counting stable cycles before accepting
// PRESSED      | press accepted, button_clean = 1
// RELEASE_WAIT | released level seen, counting stable cycles before accepting
module button_debounce
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ACTIVE_LOW      = 1,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_raw,
    output logic button_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
        $error("button_debounce: illegal parameter set");
    end

    localparam logic          INACTIVE = (ACTIVE_LOW != 0);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync_q;
    logic          pressed_s;
    button_state_e state;
    logic [CW-1:0] cnt;

    button_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (INACTIVE)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (button_raw),
        .q       (sync_q)
    );

    assign pressed_s = sync_q ^ INACTIVE;

    // Debounce FSM; the counter is shared by both wait states and cleared on every exit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            button_clean  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    button_clean <= 1'b0;
                    if (pressed_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= PRESSED;
                        cnt          <= '0;
                        button_clean <= 1'b1;
                        press_pulse  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    button_clean <= 1'b1;
                    if (!pressed_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        button_clean  <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int            LW        = $clog2(LONG_CYCLES) + 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_DONE = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_ONE  = LW'(1);

    logic [LW-1:0] long_cnt;

    // Hold timer: runs while the press is accepted, fires once, then parks past the terminal value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            long_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (state == PRESSED || state == RELEASE_WAIT) begin
                if (long_cnt == LONG_LAST) begin
                    long_press <= 1'b1;
                    long_cnt   <= LONG_DONE;
                end else if (long_cnt < LONG_LAST) begin
                    long_cnt <= long_cnt + LONG_ONE;
                end
            end else begin
                long_cnt <= '0;
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule
